mux_scan_sequencer: RTL and testbench



---
 rtl/mux_scan_sequencer_pkg.sv | 7 +
 rtl/mux_scan_sequencer_dwell_timer.sv | 19 +
 rtl/mux_scan_sequencer.sv | 84 ++++++++
 tb/tb_mux_scan_sequencer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_sequencer_pkg.sv
// mux_scan_sequencer_pkg: shared state encoding and slot constants for the scan sequencer
package mux_scan_sequencer_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, DWELL, PUSH} state_t;
  localparam int N_SLOTS = 9;
  localparam int SEL_W = 4;
  localparam logic [SEL_W-1:0] LAST_SLOT = 4'd8;
endpackage

// File: rtl/mux_scan_sequencer_dwell_timer.sv
// dwell_timer: loadable down-counter with a zero flag that holds at zero
module dwell_timer #(
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               dec,
  input  logic [DWELL_W-1:0] load_val,
  output logic               zero
);
  logic [DWELL_W-1:0] count;
  assign zero = count == '0;
  // load wins over decrement; decrement saturates at zero
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (load) count <= load_val;
    else if (dec && !zero) count <= count - 1'b1;
endmodule

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: walks a 9-way mux select, samples after a dwell and streams samples on valid/ready
module mux_scan_sequencer
  import mux_scan_sequencer_pkg::*;
#(
  parameter int WIDTH   = 1,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               one_shot,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [WIDTH-1:0]   mux_in,
  output logic [SEL_W-1:0]   sel,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_slot,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               frame_done,
  output logic               busy
);
  state_t state, nxt;
  logic ld, dec, cap, acc, zero, last;
  logic [DWELL_W-1:0] ld_val;
  assign last = sel == LAST_SLOT;
  assign ld_val = (dwell == '0) ? '0 : dwell - 1'b1;
  assign busy = state != IDLE;
  dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .load(ld),
    .dec(dec),
    .load_val(ld_val),
    .zero(zero)
  );
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  // next state and per-state control strobes
  always_comb begin
    nxt = state;
    ld = 1'b0;
    dec = 1'b0;
    cap = 1'b0;
    acc = 1'b0;
    case (state)
      IDLE: nxt = en ? SETTLE : IDLE;
      SETTLE: begin
        ld = 1'b1;
        nxt = en ? DWELL : IDLE;
      end
      DWELL: begin
        dec = en;
        cap = en && zero;
        nxt = !en ? IDLE : zero ? PUSH : DWELL;
      end
      PUSH: begin
        acc = out_ready;
        nxt = !out_ready ? PUSH : (!en || (last && one_shot)) ? IDLE : SETTLE;
      end
      default: nxt = IDLE;
    endcase
  end
  // select walk, sample capture, handshake and frame pulse
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sel <= '0;
      out_data <= '0;
      out_slot <= '0;
      out_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= acc && last;
      if (cap) begin
        out_data <= mux_in;
        out_slot <= sel;
        out_valid <= 1'b1;
      end
      if (acc) out_valid <= 1'b0;
      if (nxt == IDLE) sel <= '0;
      else if (acc) sel <= last ? '0 : sel + 1'b1;
    end
endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb_mux_scan_sequencer: scoreboard bench driving the sequencer against an external 9-way mux
module tb_mux_scan_sequencer;
  localparam int WIDTH = 8;
  localparam int DWELL_W = 16;
  logic clk = 1'b0, rst_n = 1'b1, en = 1'b0, one_shot = 1'b0, out_ready = 1'b1;
  logic [DWELL_W-1:0] dwell = '0;
  logic [WIDTH-1:0] mux_in, out_data;
  logic [3:0] sel, out_slot;
  logic out_valid, frame_done, busy;
  logic [WIDTH-1:0] src [9];
  logic [11:0] q[$];
  logic [11:0] e;
  int vec = 0, err = 0, cyc = 0, exp_per = 0, fd_cnt = 0, fd0 = 0;
  int last_acc = -1, last_fd = -1, acc8 = -1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  assign mux_in = (sel <= 4'd8) ? src[sel] : '0;

  mux_scan_sequencer #(.WIDTH(WIDTH), .DWELL_W(DWELL_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .one_shot(one_shot), .dwell(dwell),
    .mux_in(mux_in), .sel(sel), .out_data(out_data), .out_slot(out_slot),
    .out_valid(out_valid), .out_ready(out_ready), .frame_done(frame_done), .busy(busy)
  );

  task automatic chk(input string nm, input int act, input int exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sel(input logic [3:0] s, input string nm);
    for (int i = 0; i < 200 && sel != s; i++) tick();
    chk(nm, sel, s);
  endtask

  task automatic wait_valid(input string nm);
    for (int i = 0; i < 200 && !out_valid; i++) tick();
    chk(nm, out_valid, 1);
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 400 && q.size() != 0; i++) tick();
    chk(nm, q.size(), 0);
  endtask

  task automatic push_slots(input int n, input int base, input int step);
    for (int k = 0; k < n; k++) q.push_back({4'(k % 9), 8'(base + step * (k % 9))});
  endtask

  // monitor: pops expected samples on every accepted transfer and checks timing
  always @(negedge clk) begin
    if (!busy && !frame_done) begin
      last_acc = -1;
      last_fd = -1;
    end
    if (frame_done) begin
      fd_cnt++;
      chk("frame_done_after_slot8", cyc - 1, acc8);
      if (exp_per != 0 && last_fd >= 0) chk("frame_period", cyc - last_fd, 9 * exp_per);
      last_fd = cyc;
    end
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        vec++;
        err++;
        $display("FAIL unexpected_sample: got slot %0d data %0d, required no sample", out_slot, out_data);
      end else begin
        e = q.pop_front();
        chk("out_slot", out_slot, e[11:8]);
        chk("out_data", out_data, e[7:0]);
      end
      chk("sel_matches_slot", sel, out_slot);
      if (exp_per != 0 && last_acc >= 0) chk("slot_period", cyc - last_acc, exp_per);
      last_acc = cyc;
      if (out_slot == 4'd8) acc8 = cyc;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 9; i++) src[i] = 8'(10 + i);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_sel", sel, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_data", out_data, 0);
    chk("rst_slot", out_slot, 0);
    tick();
    rst_n = 1'b1;
    tick();
    // free-run three frames, dwell 3: period 5, frame 45
    dwell = 16'd3;
    one_shot = 1'b0;
    out_ready = 1'b1;
    exp_per = 5;
    push_slots(27, 10, 1);
    en = 1'b1;
    drain("freerun_drain");
    en = 1'b0;
    repeat (3) tick();
    chk("freerun_frames", fd_cnt, 3);
    chk("freerun_idle_busy", busy, 0);
    chk("freerun_idle_sel", sel, 0);
    // one-shot, dwell 0 behaves as 1: period 3, stops after slot 8
    for (int i = 0; i < 9; i++) src[i] = 8'(20 + 3 * i);
    exp_per = 3;
    dwell = 16'd0;
    one_shot = 1'b1;
    fd0 = fd_cnt;
    push_slots(9, 20, 3);
    en = 1'b1;
    drain("oneshot_drain");
    chk("oneshot_busy", busy, 0);
    chk("oneshot_sel", sel, 0);
    chk("oneshot_frame_done", frame_done, 1);
    en = 1'b0;
    repeat (2) tick();
    chk("oneshot_frames", fd_cnt - fd0, 1);
    // back-pressure on slot 4 for 7 cycles
    for (int i = 0; i < 9; i++) src[i] = 8'(40 + i);
    exp_per = 0;
    one_shot = 1'b0;
    dwell = 16'd2;
    push_slots(6, 40, 1);
    en = 1'b1;
    wait_sel(4'd4, "bp_reach_sel4");
    out_ready = 1'b0;
    wait_valid("bp_valid_rise");
    for (int i = 0; i < 7; i++) begin
      chk("bp_valid_hold", out_valid, 1);
      chk("bp_data_hold", out_data, 44);
      chk("bp_slot_hold", out_slot, 4);
      chk("bp_sel_hold", sel, 4);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("bp_valid_fall", out_valid, 0);
    chk("bp_next_sel", sel, 5);
    chk("bp_next_busy", busy, 1);
    drain("bp_drain");
    en = 1'b0;
    repeat (3) tick();
    chk("bp_idle", busy, 0);
    // en dropped during DWELL of slot 2
    for (int i = 0; i < 9; i++) src[i] = 8'(60 + i);
    dwell = 16'd4;
    push_slots(2, 60, 1);
    en = 1'b1;
    wait_sel(4'd2, "dw_reach_sel2");
    repeat (2) tick();
    en = 1'b0;
    tick();
    chk("dw_abort_busy", busy, 0);
    chk("dw_abort_sel", sel, 0);
    chk("dw_abort_valid", out_valid, 0);
    repeat (6) tick();
    chk("dw_abort_queue", q.size(), 0);
    // en dropped during PUSH of slot 6
    dwell = 16'd1;
    push_slots(7, 60, 1);
    en = 1'b1;
    wait_sel(4'd6, "push_reach_sel6");
    out_ready = 1'b0;
    wait_valid("push_valid_rise");
    en = 1'b0;
    tick();
    chk("push_en0_valid", out_valid, 1);
    chk("push_en0_slot", out_slot, 6);
    out_ready = 1'b1;
    tick();
    chk("push_en0_busy", busy, 0);
    chk("push_en0_sel", sel, 0);
    chk("push_en0_valid_fall", out_valid, 0);
    repeat (3) tick();
    chk("push_en0_queue", q.size(), 0);
    // async reset during PUSH of slot 7
    for (int i = 0; i < 9; i++) src[i] = 8'(80 + i);
    dwell = 16'd2;
    push_slots(7, 80, 1);
    en = 1'b1;
    wait_sel(4'd7, "rst_reach_sel7");
    out_ready = 1'b0;
    wait_valid("rst_valid_rise");
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_sel", sel, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_slot", out_slot, 0);
    chk("midrst_data", out_data, 0);
    chk("midrst_queue", q.size(), 0);
    tick();
    out_ready = 1'b1;
    push_slots(2, 80, 1);
    rst_n = 1'b1;
    drain("midrst_restart_drain");
    en = 1'b0;
    repeat (3) tick();
    chk("final_idle", busy, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
